// File: rtl/arb_out_buffer.sv
// Elastic output buffer between the readout arbiter and the transfer FIFO.
// RAM of DEPTH-1 words plus a first-word-fall-through output register; fill status and stats.
module arb_out_buffer #(
  parameter int DEPTH_LOG2    = 10,
  parameter int NEAR_FULL_THR = 2**10-64,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  IN_WRITE,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  IN_READY,
  output logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  input  logic                  OUT_READ,
  input  logic                  FLUSH,
  input  logic                  CLEAR_STATS,
  output logic                  FIFO_FULL,
  output logic                  FIFO_NEAR_FULL,
  output logic [DEPTH_LOG2:0]   FILL_LEVEL,
  output logic [DEPTH_LOG2:0]   HIGH_WATER,
  output logic [31:0]           WORD_COUNT,
  output logic                  OVERFLOW_ERR
);

  localparam int DEPTH     = 2**DEPTH_LOG2;
  localparam int RAM_DEPTH = DEPTH-1;
  localparam int LW        = DEPTH_LOG2+1;
  localparam int PW        = DEPTH_LOG2;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] THR_L    = LW'(NEAR_FULL_THR);
  localparam logic [PW-1:0] PTR_LAST = PW'(RAM_DEPTH-1);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [PW-1:0]         wptr, rptr;
  logic [LW-1:0]         ram_cnt;

  logic          wr_acc, rd_acc, ld, vld_nxt;
  logic [LW-1:0] ram_cnt_nxt, fill_nxt;

  // Compare-and-reset wrap so a non power-of-two RAM depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // ld: output register takes the RAM head when it is empty or being read.
  always_comb begin
    wr_acc      = IN_WRITE & IN_READY & ~FLUSH;
    rd_acc      = OUT_READ & OUT_VALID & ~FLUSH;
    ld          = (rd_acc | ~OUT_VALID) & (ram_cnt != '0) & ~FLUSH;
    ram_cnt_nxt = ram_cnt + LW'(wr_acc) - LW'(ld);
    vld_nxt     = ld | (OUT_VALID & ~rd_acc);
    if (FLUSH) begin
      ram_cnt_nxt = '0;
      vld_nxt     = 1'b0;
    end
    fill_nxt = ram_cnt_nxt + LW'(vld_nxt);
  end

  // Storage itself carries no reset; only pointers and counts define content.
  always_ff @(posedge BUS_CLK) begin
    if (wr_acc) mem[wptr] <= IN_DATA;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wptr           <= '0;
      rptr           <= '0;
      ram_cnt        <= '0;
      OUT_VALID      <= 1'b0;
      OUT_DATA       <= '0;
      IN_READY       <= 1'b0;
      FILL_LEVEL     <= '0;
      FIFO_FULL      <= 1'b0;
      FIFO_NEAR_FULL <= 1'b0;
    end else begin
      if (FLUSH) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= ptr_inc(wptr);
        if (ld) begin
          rptr     <= ptr_inc(rptr);
          OUT_DATA <= mem[rptr];
        end
      end
      ram_cnt        <= ram_cnt_nxt;
      OUT_VALID      <= vld_nxt;
      FILL_LEVEL     <= fill_nxt;
      IN_READY       <= fill_nxt < DEPTH_L;
      FIFO_FULL      <= fill_nxt == DEPTH_L;
      FIFO_NEAR_FULL <= fill_nxt >= THR_L;
    end
  end

  // Statistics ignore FLUSH except that a combined clear starts HIGH_WATER at zero.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      HIGH_WATER   <= '0;
      WORD_COUNT   <= '0;
      OVERFLOW_ERR <= 1'b0;
    end else if (CLEAR_STATS) begin
      HIGH_WATER   <= FLUSH ? '0 : FILL_LEVEL;
      WORD_COUNT   <= '0;
      OVERFLOW_ERR <= 1'b0;
    end else begin
      if (fill_nxt > HIGH_WATER) HIGH_WATER <= fill_nxt;
      if (wr_acc && (WORD_COUNT != '1)) WORD_COUNT <= WORD_COUNT + 32'd1;
      if (IN_WRITE && !IN_READY) OVERFLOW_ERR <= 1'b1;
    end
  end

endmodule
